// File: rtl/regfile_wb_scheduler_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler_if
//
// Bundles every handshake and bus signal of the write-back scheduler.
// The scalar clock, reset and flush stay as plain ports on the scheduler.
//
// Signal groups:
//   alu_*      ALU write-back request (valid/rd/data) and its ready
//   ld_*       load-unit write-back request (valid/rd/data) and its ready
//   issue_*    decode-stage instruction (valid/rs1/rs2/rd) and its stall
//   regWrite / writeReg / writeData
//              registered write port driven into the register file
//   busy       scoreboard vector, one bit per architectural register
//
// Modports:
//   master     the pipeline side; drives requests and observes the results
//   slave      the scheduler itself
// ---------------------------------------------------------------------------
interface regfile_wb_scheduler_if;

    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;

    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;

    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_stall;

    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [31:0] busy;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        output issue_valid, issue_rs1, issue_rs2, issue_rd,
        input  issue_stall,
        input  regWrite, writeReg, writeData, busy
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        input  issue_valid, issue_rs1, issue_rs2, issue_rd,
        output issue_stall,
        output regWrite, writeReg, writeData, busy
    );

endinterface

// File: rtl/regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Write-back scheduler and busy scoreboard for a 32x32 register file.
// The ALU pipe and the load unit share the file's single write port through
// a round-robin arbiter; the winning write is registered and presented on
// regWrite/writeReg/writeData. A 32-bit busy vector marks destinations with
// writes in flight and stalls issue on RAW/WAW hazards.
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset
//   flush  synchronous clear of the scoreboard (arbiter and write port keep going)
//   bus    regfile_wb_scheduler_if.slave carrying the two write-back
//          requesters, the issue port, the write port and the busy vector
// ---------------------------------------------------------------------------
module regfile_wb_scheduler (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    regfile_wb_scheduler_if.slave  bus
);

    // Which requester received the most recent grant.
    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_LD  = 1'b1
    } last_grant_t;

    last_grant_t last_grant;
    last_grant_t last_grant_next;

    logic        grant_alu;
    logic        grant_ld;
    logic [4:0]  win_rd;
    logic [31:0] win_data;
    logic        win_writes;

    logic        reg_write_q;
    logic [4:0]  write_reg_q;
    logic [31:0] write_data_q;

    logic        issue_accept;
    logic [31:0] busy_q;
    logic [31:0] busy_next;

    // Round-robin arbitration. A lone requester always wins; when both are
    // valid the one that did not win last time gets the port. The winner's
    // destination and data are muxed here so the write register only sees
    // one source.
    always_comb begin
        grant_alu       = 1'b0;
        grant_ld        = 1'b0;
        win_rd          = 5'd0;
        win_data        = 32'd0;
        last_grant_next = last_grant;
        if (bus.alu_valid && (!bus.ld_valid || last_grant == LAST_LD)) begin
            grant_alu       = 1'b1;
            win_rd          = bus.alu_rd;
            win_data        = bus.alu_data;
            last_grant_next = LAST_ALU;
        end else if (bus.ld_valid) begin
            grant_ld        = 1'b1;
            win_rd          = bus.ld_rd;
            win_data        = bus.ld_data;
            last_grant_next = LAST_LD;
        end
    end

    // Arbiter history. Reset favours the ALU on the first conflict by
    // pretending the load unit was served last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= LAST_LD;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    assign bus.alu_ready = grant_alu;
    assign bus.ld_ready  = grant_ld;

    // A grant to x0 is consumed without touching the file.
    assign win_writes = (grant_alu || grant_ld) && (win_rd != 5'd0);

    // Registered write port. Address and data only move on a real write so
    // they hold their last values while the port is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= 32'd0;
        end else begin
            reg_write_q <= win_writes;
            if (win_writes) begin
                write_reg_q  <= win_rd;
                write_data_q <= win_data;
            end
        end
    end

    assign bus.regWrite  = reg_write_q;
    assign bus.writeReg  = write_reg_q;
    assign bus.writeData = write_data_q;

    // Hazard detection: any operand or the destination still waiting for a
    // write holds the instruction. busy_q[0] is never set so x0 is free.
    assign bus.issue_stall = bus.issue_valid &
                             (busy_q[bus.issue_rs1] | busy_q[bus.issue_rs2] | busy_q[bus.issue_rd]);
    assign issue_accept    = bus.issue_valid & ~bus.issue_stall;

    // Scoreboard update. The clear for the write leaving the port is applied
    // first so a same-edge set of that bit wins; flush overrides everything.
    always_comb begin
        busy_next = busy_q;
        if (reg_write_q) begin
            busy_next[write_reg_q] = 1'b0;
        end
        if (issue_accept && bus.issue_rd != 5'd0) begin
            busy_next[bus.issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_next = 32'd0;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign bus.busy = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_scheduler
//
// Self-checking bench for regfile_wb_scheduler: reset checks, a table of
// write-back arbitration vectors, hand-written scoreboard/flush/reset
// sequences, then randomized traffic against a behavioural model.
// ---------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    regfile_wb_scheduler_if bus ();

    regfile_wb_scheduler dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        exp_ar;
        logic        exp_lr;
        logic        exp_rw;
        logic [4:0]  exp_wr;
        logic [31:0] exp_wd;
        logic        chk_wb;
    } wb_vec_t;

    wb_vec_t vecs[13];

    // Compare one observed value with the expected one and report a miss.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive a full set of inputs on the falling edge, then let combinational
    // outputs settle for one time unit.
    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                                 input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] ird, input logic fl);
        @(negedge clk);
        bus.alu_valid   = av;
        bus.alu_rd      = ard;
        bus.alu_data    = adata;
        bus.ld_valid    = lv;
        bus.ld_rd       = lrd;
        bus.ld_data     = ldata;
        bus.issue_valid = iv;
        bus.issue_rs1   = rs1;
        bus.issue_rs2   = rs2;
        bus.issue_rd    = ird;
        flush           = fl;
        #1;
    endtask

    task automatic tickEdge();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model state for the random phase.
    bit          m_busy[32];
    int          m_last;
    logic        m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    initial begin
        logic        av, lv, iv, fl;
        logic [4:0]  ard, lrd, rs1, rs2, ird;
        logic [31:0] adata, ldata;
        logic [31:0] exp_busy;
        logic        exp_stall;
        int          nreq, winner;

        // ------------------------------------------------------------ reset
        rst             = 1'b0;
        flush           = 1'b0;
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = 5'd0;
        bus.alu_data    = 32'd0;
        bus.ld_valid    = 1'b0;
        bus.ld_rd       = 5'd0;
        bus.ld_data     = 32'd0;
        bus.issue_valid = 1'b0;
        bus.issue_rs1   = 5'd0;
        bus.issue_rs2   = 5'd0;
        bus.issue_rd    = 5'd0;
        #1;
        checkOutput("reset_regWrite", 32'(bus.regWrite), 32'd0);
        checkOutput("reset_writeReg", 32'(bus.writeReg), 32'd0);
        checkOutput("reset_writeData", bus.writeData, 32'd0);
        checkOutput("reset_busy", bus.busy, 32'd0);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        #1;
        checkOutput("reset_alu_ready_follows", 32'(bus.alu_ready), 32'd1);
        tickEdge();
        checkOutput("reset_regWrite_held", 32'(bus.regWrite), 32'd0);
        @(negedge clk);
        bus.alu_valid = 1'b0;
        rst           = 1'b1;

        // ------------------------------------------------- write-back table
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 32'h33333333, 1'b0, 1'b1, 1'b1, 5'd3,  32'h33333333, 1'b1};
        vecs[3]  = '{1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2, 32'hB2B2B2B2, 1'b1, 1'b0, 1'b1, 5'd1,  32'hA1A1A1A1, 1'b1};
        vecs[4]  = '{1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2, 32'hB2B2B2B2, 1'b0, 1'b1, 1'b1, 5'd2,  32'hB2B2B2B2, 1'b1};
        vecs[5]  = '{1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2, 32'hB2B2B2B2, 1'b1, 1'b0, 1'b1, 5'd1,  32'hA1A1A1A1, 1'b1};
        vecs[6]  = '{1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2, 32'hB2B2B2B2, 1'b0, 1'b1, 1'b1, 5'd2,  32'hB2B2B2B2, 1'b1};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd2,  32'hB2B2B2B2, 1'b1};
        vecs[8]  = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0};
        vecs[9]  = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 1'b1};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4, 32'h44444444, 1'b0, 1'b1, 1'b1, 5'd4,  32'h44444444, 1'b1};
        vecs[11] = '{1'b1, 5'd6,  32'h66666666, 1'b1, 5'd8, 32'h88888888, 1'b1, 1'b0, 1'b1, 5'd6,  32'h66666666, 1'b1};
        vecs[12] = '{1'b1, 5'd10, 32'hAAAAAAAA, 1'b1, 5'd8, 32'h88888888, 1'b0, 1'b1, 1'b1, 5'd8,  32'h88888888, 1'b1};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].av, vecs[i].ard, vecs[i].adata,
                          vecs[i].lv, vecs[i].lrd, vecs[i].ldata,
                          1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            checkOutput($sformatf("vec%0d_alu_ready", i), 32'(bus.alu_ready), 32'(vecs[i].exp_ar));
            checkOutput($sformatf("vec%0d_ld_ready", i), 32'(bus.ld_ready), 32'(vecs[i].exp_lr));
            tickEdge();
            checkOutput($sformatf("vec%0d_regWrite", i), 32'(bus.regWrite), 32'(vecs[i].exp_rw));
            if (vecs[i].chk_wb) begin
                checkOutput($sformatf("vec%0d_writeReg", i), 32'(bus.writeReg), 32'(vecs[i].exp_wr));
                checkOutput($sformatf("vec%0d_writeData", i), bus.writeData, vecs[i].exp_wd);
            end
            checkOutput($sformatf("vec%0d_busy", i), bus.busy, 32'd0);
        end

        // ------------------------------------------------ scoreboard / RAW
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd7, 1'b0);
        checkOutput("sb_issue7_stall", 32'(bus.issue_stall), 32'd0);
        tickEdge();
        checkOutput("sb_busy7_set", bus.busy, 32'h0000_0080);
        applyStimulus(1'b1, 5'd7, 32'h77777777, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
        checkOutput("sb_raw_stall", 32'(bus.issue_stall), 32'd1);
        checkOutput("sb_alu7_ready", 32'(bus.alu_ready), 32'd1);
        tickEdge();
        checkOutput("sb_rw7", 32'(bus.regWrite), 32'd1);
        checkOutput("sb_wr7", 32'(bus.writeReg), 32'd7);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
        checkOutput("sb_stall_during_write", 32'(bus.issue_stall), 32'd1);
        tickEdge();
        checkOutput("sb_busy7_clear", bus.busy, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
        checkOutput("sb_stall_dropped", 32'(bus.issue_stall), 32'd0);

        // ------------------------------------------------------------ x0
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("x0_no_stall", 32'(bus.issue_stall), 32'd0);
        tickEdge();
        checkOutput("x0_busy_unset", bus.busy, 32'd0);

        // ------------------------------- same-edge set and clear: set wins
        applyStimulus(1'b1, 5'd12, 32'h0C0C0C0C, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tickEdge();
        checkOutput("setwin_rw12", 32'(bus.regWrite), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd12, 1'b0);
        checkOutput("setwin_no_stall", 32'(bus.issue_stall), 32'd0);
        tickEdge();
        checkOutput("setwin_busy12", bus.busy, 32'h0000_1000);

        // ----------------------------------------------------- WAW / flush
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b0);
        tickEdge();
        checkOutput("waw_busy9", bus.busy, 32'h0000_1200);
        applyStimulus(1'b1, 5'd9, 32'h99999999, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        checkOutput("waw_stall", 32'(bus.issue_stall), 32'd1);
        checkOutput("waw_alu_ready", 32'(bus.alu_ready), 32'd1);
        tickEdge();
        checkOutput("flush_busy", bus.busy, 32'd0);
        checkOutput("flush_rw", 32'(bus.regWrite), 32'd1);
        checkOutput("flush_wr", 32'(bus.writeReg), 32'd9);
        checkOutput("flush_wd", bus.writeData, 32'h99999999);

        // ------------------------------------------------- async reset
        applyStimulus(1'b1, 5'd20, 32'h20202020, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd15, 1'b0);
        tickEdge();
        checkOutput("arst_pre_rw", 32'(bus.regWrite), 32'd1);
        checkOutput("arst_pre_busy", bus.busy, 32'h0000_8000);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_rw", 32'(bus.regWrite), 32'd0);
        checkOutput("arst_busy", bus.busy, 32'd0);
        checkOutput("arst_wr", 32'(bus.writeReg), 32'd0);
        checkOutput("arst_wd", bus.writeData, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        rst = 1'b1;

        // ------------------------------------------ randomized vs model
        // Model: winner is the only requester, or under contention the one
        // not served last; busy is a set of registers awaiting a write.
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        m_last = 2;
        m_rw   = 1'b0;
        m_wr   = 5'd0;
        m_wd   = 32'd0;
        av = 1'b0; ard = 5'd0; adata = 32'd0;
        lv = 1'b0; lrd = 5'd0; ldata = 32'd0;

        for (int c = 0; c < 300; c++) begin
            if (!av) begin
                av    = ($urandom_range(0, 2) != 0);
                ard   = 5'($urandom_range(0, 15));
                adata = $urandom;
            end
            if (!lv) begin
                lv    = ($urandom_range(0, 2) != 0);
                lrd   = 5'($urandom_range(0, 15));
                ldata = $urandom;
            end
            iv  = ($urandom_range(0, 1) != 0);
            rs1 = 5'($urandom_range(0, 15));
            rs2 = 5'($urandom_range(0, 15));
            ird = 5'($urandom_range(0, 15));
            fl  = ($urandom_range(0, 15) == 0);

            applyStimulus(av, ard, adata, lv, lrd, ldata, iv, rs1, rs2, ird, fl);

            nreq = int'(av) + int'(lv);
            if (nreq == 0)      winner = 0;
            else if (nreq == 1) winner = av ? 1 : 2;
            else                winner = (m_last == 1) ? 2 : 1;
            exp_stall = iv && (m_busy[rs1] || m_busy[rs2] || m_busy[ird]);

            checkOutput($sformatf("rnd%0d_alu_ready", c), 32'(bus.alu_ready), 32'(winner == 1));
            checkOutput($sformatf("rnd%0d_ld_ready", c), 32'(bus.ld_ready), 32'(winner == 2));
            checkOutput($sformatf("rnd%0d_stall", c), 32'(bus.issue_stall), 32'(exp_stall));

            if (m_rw) m_busy[m_wr] = 1'b0;
            if (iv && !exp_stall && ird != 5'd0) m_busy[ird] = 1'b1;
            if (fl) for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;

            m_rw = 1'b0;
            if (winner == 1) begin
                m_last = 1;
                if (ard != 5'd0) begin m_rw = 1'b1; m_wr = ard; m_wd = adata; end
                av = 1'b0;
            end else if (winner == 2) begin
                m_last = 2;
                if (lrd != 5'd0) begin m_rw = 1'b1; m_wr = lrd; m_wd = ldata; end
                lv = 1'b0;
            end

            tickEdge();
            exp_busy = 32'd0;
            for (int r = 0; r < 32; r++) exp_busy[r] = m_busy[r];
            checkOutput($sformatf("rnd%0d_regWrite", c), 32'(bus.regWrite), 32'(m_rw));
            checkOutput($sformatf("rnd%0d_writeReg", c), 32'(bus.writeReg), 32'(m_wr));
            checkOutput($sformatf("rnd%0d_writeData", c), bus.writeData, m_wd);
            checkOutput($sformatf("rnd%0d_busy", c), bus.busy, exp_busy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    // Absolute time limit so the bench cannot hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no completion expected finish before time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
